// File: rtl/pwm_burst_ctrl.sv
// pwm_burst_ctrl
// Sequencer for the PWM datapath. It owns the period counter, the active and
// shadow period/duty registers and the periods-left counter. It runs either
// continuous PWM or a fixed-length burst of periods on start/stop commands.
// Configuration writes land in shadow registers and reach the active
// registers only at start or at a period boundary, so a period never changes
// shape while it is running.
//
// Ports:
//   i_clock         single clock, all state updates on the rising edge
//   i_reset         synchronous active-high reset
//   i_start         level-sampled, begins a run when idle
//   i_stop          level-sampled, aborts a run at once (beats a boundary)
//   i_cfg_we        writes period/duty/burst into the shadow registers
//   i_cfg_period    period length in cycles (0 behaves as 1)
//   i_cfg_duty      high cycles per period
//   i_cfg_burst     periods per run, 0 = continuous
//   o_pwm_out       registered PWM output
//   o_busy          high while running
//   o_period_done   one-cycle pulse after each completed period
//   o_done          one-cycle pulse when a burst ends normally
module pwm_burst_ctrl #(
  parameter int WIDTH  = 8,
  parameter int BURSTW = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_cfg_we,
  input  logic [WIDTH-1:0]  i_cfg_period,
  input  logic [WIDTH-1:0]  i_cfg_duty,
  input  logic [BURSTW-1:0] i_cfg_burst,
  output logic              o_pwm_out,
  output logic              o_busy,
  output logic              o_period_done,
  output logic              o_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_actPeriod;
  logic [WIDTH-1:0]   r_actDuty;
  logic [WIDTH-1:0]   r_shPeriod;
  logic [WIDTH-1:0]   r_shDuty;
  logic [BURSTW-1:0]  r_shBurst;
  logic [BURSTW-1:0]  r_left;
  logic               r_pwm;
  logic               r_periodDone;
  logic               r_done;

  state_t             w_nextState;
  logic [WIDTH-1:0]   w_cnt;
  logic [WIDTH-1:0]   w_actPeriod;
  logic [WIDTH-1:0]   w_actDuty;
  logic [BURSTW-1:0]  w_left;
  logic               w_pwm;
  logic               w_periodDone;
  logic               w_done;
  logic [WIDTH-1:0]   w_lastCnt;
  logic [WIDTH-1:0]   w_cntInc;
  logic               w_burstMode;

  // A programmed period of 0 runs as a 1-cycle period, so the last count
  // value is 0 in that case and the subtraction can never underflow.
  assign w_lastCnt   = (r_actPeriod == '0) ? '0 : r_actPeriod - WIDTH'(1);
  assign w_cntInc    = r_cnt + WIDTH'(1);
  // Continuous runs load 0 into periods-left and never touch it, so a
  // non-zero value identifies a burst.
  assign w_burstMode = (r_left != '0);

  // Next-state logic. The registered PWM level is computed from the count and
  // duty that will be live next cycle, keeping pwm_out == (cnt < duty) while
  // busy. Boundary reloads read the shadow values from before any write on
  // the same edge, which defers such a write by one period.
  always_comb begin
    w_nextState  = r_state;
    w_cnt        = r_cnt;
    w_actPeriod  = r_actPeriod;
    w_actDuty    = r_actDuty;
    w_left       = r_left;
    w_pwm        = 1'b0;
    w_periodDone = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) begin
          w_nextState = RUN;
          w_actPeriod = r_shPeriod;
          w_actDuty   = r_shDuty;
          w_left      = r_shBurst;
          w_cnt       = '0;
          w_pwm       = (r_shDuty != '0);
        end
      end
      RUN: begin
        if (i_stop) begin
          w_nextState = IDLE;
          w_cnt       = '0;
        end else if (r_cnt == w_lastCnt) begin
          w_periodDone = 1'b1;
          w_cnt        = '0;
          if (w_burstMode && (r_left == BURSTW'(1))) begin
            w_nextState = IDLE;
            w_done      = 1'b1;
          end else begin
            w_actPeriod = r_shPeriod;
            w_actDuty   = r_shDuty;
            w_pwm       = (r_shDuty != '0);
            if (w_burstMode) begin
              w_left = r_left - BURSTW'(1);
            end
          end
        end else begin
          w_cnt = w_cntInc;
          w_pwm = (w_cntInc < r_actDuty);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and datapath registers; shadow writes are accepted in any state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_actPeriod  <= '1;
      r_actDuty    <= '0;
      r_shPeriod   <= '1;
      r_shDuty     <= '0;
      r_shBurst    <= '0;
      r_left       <= '0;
      r_pwm        <= 1'b0;
      r_periodDone <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_cnt;
      r_actPeriod  <= w_actPeriod;
      r_actDuty    <= w_actDuty;
      r_left       <= w_left;
      r_pwm        <= w_pwm;
      r_periodDone <= w_periodDone;
      r_done       <= w_done;
      if (i_cfg_we) begin
        r_shPeriod <= i_cfg_period;
        r_shDuty   <= i_cfg_duty;
        r_shBurst  <= i_cfg_burst;
      end
    end
  end

  assign o_pwm_out     = r_pwm;
  assign o_busy        = (r_state == RUN);
  assign o_period_done = r_periodDone;
  assign o_done        = r_done;

endmodule

// File: tb/tb_pwm_burst_ctrl.sv
// tb_pwm_burst_ctrl
// Directed bench for pwm_burst_ctrl. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, so every sample shows the
// state registered by the preceding edge. "Cycle k" is the cycle after the
// k-th edge counted from the edge that samples start.
module tb_pwm_burst_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       cfgWe;
  logic [7:0] cfgPeriod;
  logic [7:0] cfgDuty;
  logic [7:0] cfgBurst;
  logic       pwmOut;
  logic       busy;
  logic       periodDone;
  logic       done;

  int testsRun;
  int testsFailed;

  pwm_burst_ctrl #(.WIDTH(8), .BURSTW(8)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_start       (start),
    .i_stop        (stop),
    .i_cfg_we      (cfgWe),
    .i_cfg_period  (cfgPeriod),
    .i_cfg_duty    (cfgDuty),
    .i_cfg_burst   (cfgBurst),
    .o_pwm_out     (pwmOut),
    .o_busy        (busy),
    .o_period_done (periodDone),
    .o_done        (done)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the command and configuration inputs for the coming edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic we,
                               input logic [7:0] p, input logic [7:0] d,
                               input logic [7:0] b);
    start     = st;
    stop      = sp;
    cfgWe     = we;
    cfgPeriod = p;
    cfgDuty   = d;
    cfgBurst  = b;
  endtask

  // Write a configuration while idle, then start a run; returns in cycle 1.
  task automatic configAndStart(input logic [7:0] p, input logic [7:0] d,
                                input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 1'b1, p, d, b);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, p, d, b);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, p, d, b);
  endtask

  // Abort the current run and confirm the block is idle again.
  task automatic stopRun(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput({tag, " busy after stop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [8:0]  expPwm9;
    logic [8:0]  expPd9;
    logic [8:0]  expDone9;
    logic [8:0]  expBusy9;
    logic [15:0] expPwm16;
    logic [15:0] expPd16;
    int          waitCycles;
    logic        sawHigh;

    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Reset for two edges, then run on the default shadow (P=255, D=0).
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset pwm", 32'(pwmOut), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset period_done", 32'(periodDone), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("default busy c1", 32'(busy), 32'd1);
    waitCycles = 0;
    sawHigh    = 1'b0;
    while (!periodDone && waitCycles < 300) begin
      tick();
      waitCycles++;
      if (pwmOut) sawHigh = 1'b1;
    end
    checkOutput("default period length", 32'(waitCycles), 32'd255);
    checkOutput("default pwm stays low", 32'(sawHigh), 32'd0);
    stopRun("default");

    // Burst of 2 periods, P=4 D=1; bit i is cycle i+1.
    expPwm9  = 9'b000010001;
    expPd9   = 9'b100010000;
    expDone9 = 9'b100000000;
    expBusy9 = 9'b011111111;
    configAndStart(8'd4, 8'd1, 8'd2);
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("burst2 pwm c%0d", c), 32'(pwmOut), 32'(expPwm9[c-1]));
      checkOutput($sformatf("burst2 period_done c%0d", c), 32'(periodDone), 32'(expPd9[c-1]));
      checkOutput($sformatf("burst2 done c%0d", c), 32'(done), 32'(expDone9[c-1]));
      checkOutput($sformatf("burst2 busy c%0d", c), 32'(busy), 32'(expBusy9[c-1]));
      tick();
    end
    checkOutput("burst2 done c10", 32'(done), 32'd0);

    // Continuous P=5 D=2; mid-period write P=3 D=3 in cycle 2, and a write
    // P=4 D=1 on the boundary edge ending cycle 8 that must wait a period.
    expPwm16 = 16'b1000111111100011;
    expPd16  = 16'b1000100100100000;
    configAndStart(8'd5, 8'd2, 8'd0);
    for (int c = 1; c <= 16; c++) begin
      checkOutput($sformatf("shadow pwm c%0d", c), 32'(pwmOut), 32'(expPwm16[c-1]));
      checkOutput($sformatf("shadow period_done c%0d", c), 32'(periodDone), 32'(expPd16[c-1]));
      if (c == 2) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 8'd3, 8'd0);
      end else if (c == 8) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd4, 8'd1, 8'd0);
      end else begin
        cfgWe = 1'b0;
      end
      tick();
    end
    stopRun("shadow");

    // Stop at cnt=2 of P=8 D=3.
    configAndStart(8'd8, 8'd3, 8'd0);
    tick();
    tick();
    checkOutput("stop pwm before", 32'(pwmOut), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop busy", 32'(busy), 32'd0);
    checkOutput("stop pwm", 32'(pwmOut), 32'd0);
    checkOutput("stop period_done", 32'(periodDone), 32'd0);
    checkOutput("stop done", 32'(done), 32'd0);

    // Stop on the final boundary of a 1-period burst: abort, no done.
    configAndStart(8'd4, 8'd1, 8'd1);
    tick();
    tick();
    tick();
    checkOutput("final stop busy before", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("final stop busy", 32'(busy), 32'd0);
    checkOutput("final stop done", 32'(done), 32'd0);
    checkOutput("final stop period_done", 32'(periodDone), 32'd0);

    // P=0 behaves as 1-cycle periods with D=1 high throughout.
    configAndStart(8'd0, 8'd1, 8'd0);
    checkOutput("p0 period_done c1", 32'(periodDone), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("p0 pwm c%0d", c), 32'(pwmOut), 32'd1);
      if (c > 1) begin
        checkOutput($sformatf("p0 period_done c%0d", c), 32'(periodDone), 32'd1);
      end
      tick();
    end
    stopRun("p0");

    // D=0 stays low.
    configAndStart(8'd3, 8'd0, 8'd0);
    for (int c = 1; c <= 6; c++) begin
      checkOutput($sformatf("d0 pwm c%0d", c), 32'(pwmOut), 32'd0);
      tick();
    end
    stopRun("d0");

    // D=255 with P=10 stays high, across a boundary.
    configAndStart(8'd10, 8'd255, 8'd0);
    for (int c = 1; c <= 12; c++) begin
      checkOutput($sformatf("dmax pwm c%0d", c), 32'(pwmOut), 32'd1);
      tick();
    end
    stopRun("dmax");

    // start and stop together while idle: no run.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 8'd2, 8'd0);
    tick();
    checkOutput("start+stop busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd4, 8'd2, 8'd0);
    checkOutput("start+stop busy again", 32'(busy), 32'd0);

    // Reset mid-run, then restart on the reset shadow (P=255, D=0).
    configAndStart(8'd4, 8'd2, 8'd0);
    tick();
    checkOutput("midreset pwm before", 32'(pwmOut), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset pwm", 32'(pwmOut), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset period_done", 32'(periodDone), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart busy", 32'(busy), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      checkOutput($sformatf("restart pwm c%0d", c), 32'(pwmOut), 32'd0);
      checkOutput($sformatf("restart period_done c%0d", c), 32'(periodDone), 32'd0);
      tick();
    end
    stopRun("restart");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pwm_burst_ctrl.md
# pwm_burst_ctrl

Sequencer for the PWM datapath. It owns the period counter and the active and shadow duty/period registers, and runs continuous or fixed-length bursts of PWM periods on `start` and `stop` commands. Configuration writes go to shadow registers and take effect only at period boundaries, so the output never glitches mid-period. The block sits between the register/command interface and the PWM output pin, and replaces ad-hoc load/enable sequencing of the counter.

## Interface
Parameters:
- `WIDTH`, 8, width of period, duty and counter.
- `BURSTW`, 8, width of burst length and periods-left counter.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `start`  in  1  level-sampled; begins a run when idle.
- `stop`  in  1  level-sampled; aborts a run immediately.
- `cfg_we`  in  1  writes `cfg_period`, `cfg_duty` and `cfg_burst` into the shadow registers.
- `cfg_period`  in  WIDTH  period length P in cycles; 0 is treated as 1.
- `cfg_duty`  in  WIDTH  high cycles per period D.
- `cfg_burst`  in  BURSTW  periods per run; 0 means continuous.
- `pwm_out`  out  1  registered PWM output.
- `busy`  out  1  high while in RUN.
- `period_done`  out  1  one-cycle pulse after each completed period.
- `done`  out  1  one-cycle pulse when a burst completes normally.

## Operation
- **States:** IDLE and RUN. `busy` = (state == RUN).
- **Reset:**
  - State = IDLE; `cnt` = 0.
  - `pwm_out`, `period_done` and `done` = 0.
  - Shadow registers: period = 2^WIDTH−1, duty = 0, burst = 0.
  - Active registers: period = 2^WIDTH−1, duty = 0.
  - Periods-left counter = 0.
- **Shadow write:** `cfg_we` updates all three shadow registers at the edge, in either state. It never directly affects the active registers.
- **Effective period:** Pe = max(active period, 1).
- **IDLE:**
  - `start` && !`stop` → RUN.
  - Load active period and duty from shadow, load periods-left from shadow burst, set `cnt` = 0.
  - `start` while in RUN is ignored.
- **RUN, per cycle:**
  - If `stop`: go to IDLE, `pwm_out` = 0, `cnt` = 0. No `done` and no `period_done` pulse. `stop` has priority over a boundary.
  - Else if `cnt` == Pe−1 (boundary):
    - Pulse `period_done`.
    - If burst mode and periods-left == 1: go to IDLE, pulse `done`, `pwm_out` = 0.
    - Otherwise: `cnt` = 0, copy shadow period and duty into active, and decrement periods-left (burst mode only).
  - Else: `cnt` = `cnt` + 1.
- **Output invariant:** in every cycle with `busy` = 1, `pwm_out` == (`cnt` < active duty). `pwm_out` is registered alongside `cnt`.
  - D = 0: output constant low.
  - D ≥ Pe: output constant high.
- **Width rules:**
  - `cnt` compare is unsigned over WIDTH bits.
  - Pe−1 cannot underflow, because Pe ≥ 1.
  - Periods-left never wraps: decrement happens only when it is > 1, and it is never touched in continuous mode.
- **Simultaneous events:**
  - `cfg_we` at a boundary or start edge: the active registers take the old shadow values; the new values apply at the next boundary.
  - `start` && `stop` in IDLE: remain IDLE.
  - `stop` at the final boundary: abort semantics, so no `done`.
- **Reset mid-run:** returns to the reset state at the next edge. All outputs are low in the following cycle.

## Timing
- **Start latency:** start sampled at edge E0. Cycle after E0: `busy` = 1, `cnt` = 0, `pwm_out` = (D ≠ 0).
- **Period:** exactly Pe cycles (`cnt` 0..Pe−1). No idle cycle between periods.
- **Pulses:** `period_done` and `done` are high in the cycle immediately after the boundary edge, i.e. coincident with the next period's `cnt` = 0, or with IDLE after the final period.
- **Stop latency:** `stop` sampled at edge Es. Cycle after Es: `busy` = 0, `pwm_out` = 0.
- **Burst length:** a burst of N periods keeps `busy` high for N·Pe cycles.

## Test plan
- **Reset:** assert `reset` for 2 cycles, then release. All outputs 0, and `start` with the default shadow gives P = 255, D = 0: `pwm_out` stays low and `period_done` occurs every 255 cycles.
- **Burst of 2:** P = 4, D = 1, burst = 2, `start` at edge 0. `pwm_out` = 1,0,0,0,1,0,0,0 in cycles 1–8. `period_done` in cycles 5 and 9; `done` in cycle 9; `busy` low from cycle 9.
- **Shadow update:** P = 5, D = 2, continuous. Mid-period write P = 3, D = 3. The current period finishes as 5 cycles with 2 high; subsequent periods are 3 cycles, all high. A write coincident with the boundary is deferred one period.
- **Stop:** `stop` at `cnt` = 2 of P = 8. `busy` = 0 and `pwm_out` = 0 next cycle; no `done` or `period_done`. `stop` at the final boundary of a burst gives no `done`.
- **Edge values:**
  - P = 0, D = 1: 1-cycle periods, `pwm_out` constant 1, `period_done` every cycle.
  - D = 0: always low.
  - D = 255 with P = 10: always high.
  - `start` + `stop` together in IDLE: stays IDLE.
- **Reset mid-run:** assert `reset` during RUN. Next cycle all outputs 0. A new `start` then uses the reset shadow values, not the prior configuration.
